mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning complex samples packed per MAC operand word; only 4 is supported.
REQ-002 SHALL have parameter TMO_CYC, default 255, meaning the watchdog limit in clocks; used only under MAC_FEEDER_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream sample present.
REQ-006 SHALL have port in_ready  output  1  feeder accepts a sample this cycle.
REQ-007 SHALL have port in_x  input  8  X sample, 4-bit real in [3:0] and 4-bit imag in [7:4].
REQ-008 SHALL have port in_y  input  8  Y sample, same packing as in_x.
REQ-009 SHALL have port mac_x  output  32  packed X operand to the MAC.
REQ-010 SHALL have port mac_y  output  32  packed Y operand to the MAC.
REQ-011 SHALL have port mac_start  output  1  MAC start request.
REQ-012 SHALL have port mac_ready  input  1  MAC ready: high when idle, low while busy.
REQ-013 SHALL have port mac_out  input  20  MAC result, real in [19:10] and imag in [9:0].
REQ-014 SHALL have port res_valid  output  1  one-cycle pulse when the result registers update.
REQ-015 SHALL have port res_real  output  10  registered real result.
REQ-016 SHALL have port res_imag  output  10  registered imag result.
REQ-017 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement the states FILL, START and WAIT_DONE.
REQ-019 SHALL drive in_ready=1 only in FILL; a handshake occurs when in_valid && in_ready.
REQ-020 SHALL store handshake k (k=0..3) of a batch into lane k: mac_x[8k+7:8k]=in_x and mac_y[8k+7:8k]=in_y.
REQ-021 SHALL use a 2-bit lane counter that wraps 3->0; after the handshake at lane 3 the state goes FILL->START on the next edge.
REQ-022 SHALL hold mac_x and mac_y stable outside FILL handshakes.
REQ-023 SHALL drive mac_start=1 throughout START; START->WAIT_DONE when mac_ready is sampled 0, otherwise stay in START.
REQ-024 In WAIT_DONE, mac_ready sampled 1 SHALL capture res_real=mac_out[19:10] and res_imag=mac_out[9:0], pulse res_valid for one cycle and return to FILL with lane counter 0.
REQ-025 SHALL accept no samples while in START or WAIT_DONE; in_valid held high stalls upstream with no loss.
REQ-026 SHALL produce res_valid no earlier than 2 cycles after entering START.
REQ-027 SHALL pass the result values through unchanged, with no saturation or sign handling.

Reset
REQ-028 On rst SHALL immediately give: state FILL, lane counter 0, mac_x=mac_y=0, mac_start=0, res_valid=0, res_real=res_imag=0, err=0.
REQ-029 SHALL discard a partial batch or an in-flight MAC operation on reset mid-operation; no res_valid for it.

Configuration
REQ-030 With MAC_FEEDER_TIMEOUT_EN defined, SHALL run an 8-bit cycle counter that clears on entering START and counts in START and WAIT_DONE.
REQ-031 With MAC_FEEDER_TIMEOUT_EN defined, when the counter reaches TMO_CYC the feeder SHALL set err (sticky until rst) and return to FILL with no res_valid.
REQ-032 Without MAC_FEEDER_TIMEOUT_EN, SHALL have no counter, tie err to 0 and wait indefinitely in START and WAIT_DONE.

Structure
REQ-033 SHALL place the state enum, LANE_W=8, RES_W=10 and the default TMO_CYC in shared package mac_feeder_pkg.
REQ-034 SHALL implement lane packing (lane counter plus 4x8-bit X/Y registers) in a single sub-module, mac_feeder_pack; the FSM stays in mac_feeder.

Verification
REQ-035 Bench SHALL cover: samples (x,y)=(0x70,0x70),(0x57,0x25),(0x25,0x14),(0x53,0x35) with in_valid held high -> mac_x=0x53255770, mac_y=0x35142570, in_ready low from the cycle after the 4th handshake.
REQ-036 Bench SHALL cover: MAC model holds mac_ready=1 for 3 cycles after mac_start rises -> mac_start stays high until mac_ready=0 and the FSM stays in START.
REQ-037 Bench SHALL cover: MAC model returns mac_out=0x2A0C5 -> res_valid exactly one cycle, res_real=0x0A8, res_imag=0x0C5, in_ready=1 the next cycle.
REQ-038 Bench SHALL cover: rst asserted after 2 handshakes, then 4 fresh samples -> lanes 0..3 hold only the fresh samples and no res_valid from the aborted batch.
REQ-039 Bench SHALL cover, with MAC_FEEDER_TIMEOUT_EN and TMO_CYC=255: mac_ready stuck 0 -> err=1 after 255 cycles, state FILL, no res_valid; without the macro err stays 0.
REQ-040 Bench SHALL cover: two back-to-back batches -> two res_valid pulses, second batch lanes not corrupted by the first.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg
//   Types and constants shared by the MAC feeder files: FSM state encoding,
//   lane/result widths and the default watchdog limit.
package mac_feeder_pkg;

    localparam int LANE_W          = 8;    // one complex sample: imag[7:4], real[3:0]
    localparam int RES_W           = 10;   // each half of the MAC result
    localparam int N_LANES         = 4;    // samples per MAC operand word
    localparam int TMO_CYC_DEFAULT = 255;  // watchdog limit in clocks

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_feeder_if.sv
// mac_feeder_if
//   Bundles the upstream sample handshake, the MAC operand/result bus and the
//   feeder status outputs.
//   slave  : the feeder side (mac_feeder)
//   master : the environment side (sample source, MAC and result sink)
//   Signals: in_valid/in_ready/in_x/in_y   upstream samples
//            mac_x/mac_y/mac_start         operands and start request to the MAC
//            mac_ready/mac_out             MAC status and result
//            res_valid/res_real/res_imag   registered result
//            err                           sticky watchdog flag
interface mac_feeder_if;
    import mac_feeder_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [LANE_W-1:0]           in_x;
    logic [LANE_W-1:0]           in_y;
    logic [N_LANES*LANE_W-1:0]   mac_x;
    logic [N_LANES*LANE_W-1:0]   mac_y;
    logic                        mac_start;
    logic                        mac_ready;
    logic [2*RES_W-1:0]          mac_out;
    logic                        res_valid;
    logic [RES_W-1:0]            res_real;
    logic [RES_W-1:0]            res_imag;
    logic                        err;

    modport slave (
        input  in_valid, in_x, in_y, mac_ready, mac_out,
        output in_ready, mac_x, mac_y, mac_start,
               res_valid, res_real, res_imag, err
    );

    modport master (
        output in_valid, in_x, in_y, mac_ready, mac_out,
        input  in_ready, mac_x, mac_y, mac_start,
               res_valid, res_real, res_imag, err
    );

endinterface

// File: rtl/mac_feeder_pack.sv
// mac_feeder_pack
//   Lane packer: writes each accepted sample pair into the next 8-bit lane of
//   the X/Y operand registers. The 2-bit lane counter wraps 3->0, so a full
//   batch always leaves it at lane 0 for the next one.
//   clk, rst     clock, async active-high reset
//   load         accept in_x/in_y into the current lane
//   in_x, in_y   sample pair
//   mac_x, mac_y packed operands (lane k in bits [8k+7:8k]); held between loads
//   last         current lane is lane 3
module mac_feeder_pack
    import mac_feeder_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [LANE_W-1:0]         in_x,
    input  logic [LANE_W-1:0]         in_y,
    output logic [N_LANES*LANE_W-1:0] mac_x,
    output logic [N_LANES*LANE_W-1:0] mac_y,
    output logic                      last
);

    logic [1:0] lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane  <= '0;
            mac_x <= '0;
            mac_y <= '0;
        end else if (load) begin
            for (int k = 0; k < N_LANES; k++) begin
                if (lane == 2'(k)) begin
                    mac_x[k*LANE_W +: LANE_W] <= in_x;
                    mac_y[k*LANE_W +: LANE_W] <= in_y;
                end
            end
            lane <= lane + 2'd1;
        end
    end

    assign last = (lane == 2'd3);

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder
//   Collects four complex sample pairs into packed MAC operands, requests a
//   MAC operation, waits for it to finish and registers the result.
//   Optional watchdog: define MAC_FEEDER_TIMEOUT_EN to abort a MAC operation
//   that does not finish within TMO_CYC clocks (sets sticky err). Without it
//   err is tied low and the feeder waits indefinitely.
//   Parameters: LANES (must be 4), TMO_CYC (watchdog limit, 1..255)
//   Ports: clk, rst (async active-high), bus (mac_feeder_if.slave)
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FILL      | accepting samples into lanes 0..3 (in_ready=1)
//   START     | operands complete, mac_start=1 until MAC drops mac_ready
//   WAIT_DONE | MAC busy; capture result when mac_ready returns high
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int LANES   = N_LANES,
    parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    mac_feeder_if.slave bus
);

    if (LANES != N_LANES) begin : g_lanes_chk
        $error("mac_feeder: only LANES=4 is supported");
    end
    if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_chk
        $error("mac_feeder: TMO_CYC must fit the 8-bit watchdog (1..255)");
    end

    state_t                    state;
    logic                      in_ready_q;
    logic                      mac_start_q;
    logic                      res_valid_q;
    logic [RES_W-1:0]          res_real_q;
    logic [RES_W-1:0]          res_imag_q;
    logic                      load;
    logic                      last;
    logic                      tmo_hit;
    logic [N_LANES*LANE_W-1:0] mac_x_w;
    logic [N_LANES*LANE_W-1:0] mac_y_w;

    // in_ready_q is registered alongside state and is high exactly in FILL.
    assign load = bus.in_valid && in_ready_q;

    mac_feeder_pack u_pack (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .in_x  (bus.in_x),
        .in_y  (bus.in_y),
        .mac_x (mac_x_w),
        .mac_y (mac_y_w),
        .last  (last)
    );

`ifdef MAC_FEEDER_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    // START is only ever entered from FILL, so clearing throughout FILL
    // gives a count of 0 on the first START cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == FILL) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Fires on the edge at which the counter would reach TMO_CYC.
    assign tmo_hit = (state != FILL) && (tmo_cnt == 8'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    // Every exit to FILL leaves the lane counter at 0: either the batch
    // completed (counter wrapped) or no handshake happened since.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            in_ready_q  <= 1'b1;
            mac_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_real_q  <= '0;
            res_imag_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state)
                FILL: begin
                    if (load && last) begin
                        state       <= START;
                        in_ready_q  <= 1'b0;
                        mac_start_q <= 1'b1;
                    end
                end
                START: begin
                    if (tmo_hit) begin
                        state       <= FILL;
                        in_ready_q  <= 1'b1;
                        mac_start_q <= 1'b0;
                    end else if (!bus.mac_ready) begin
                        state       <= WAIT_DONE;
                        mac_start_q <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    // A watchdog expiry discards the operation even if the
                    // MAC reports done on the same edge.
                    if (tmo_hit) begin
                        state      <= FILL;
                        in_ready_q <= 1'b1;
                    end else if (bus.mac_ready) begin
                        state       <= FILL;
                        in_ready_q  <= 1'b1;
                        res_valid_q <= 1'b1;
                        res_real_q  <= bus.mac_out[2*RES_W-1:RES_W];
                        res_imag_q  <= bus.mac_out[RES_W-1:0];
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready_q  <= 1'b1;
                    mac_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mac_start = mac_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_real  = res_real_q;
    assign bus.res_imag  = res_imag_q;
    assign bus.mac_x     = mac_x_w;
    assign bus.mac_y     = mac_y_w;

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
//   Self-checking bench for mac_feeder: table of directed batches, reset
//   corner cases, watchdog behaviour (both builds) and randomized batches
//   checked against a lane/result reference model.
module tb_mac_feeder;
    import mac_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_feeder_if bus ();

    mac_feeder #(
        .LANES   (4),
        .TMO_CYC (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   errors   = 0;
    int   rv_count = 0;
    int   exp_rv   = 0;
    logic exp_err  = 1'b0;

    // Reference lane contents, indexed by lane.
    logic [7:0] mx [4];
    logic [7:0] my [4];

    typedef struct {
        logic [31:0] xs;    // samples in arrival order, first in [31:24]
        logic [31:0] ys;
        logic [19:0] res;
        int          pre;   // cycles mac_ready stays high after mac_start
        bit          hold;  // present next batch's first sample during MAC
        logic [31:0] ex;
        logic [31:0] ey;
        logic [9:0]  er;
        logic [9:0]  ei;
    } vec_t;

    vec_t tbl [4];

    // Pulses are counted on the edge that ends them.
    always @(posedge clk) begin
        if (bus.res_valid) rv_count <= rv_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] lanes_x();
        return {mx[3], mx[2], mx[1], mx[0]};
    endfunction

    function automatic logic [31:0] lanes_y();
        return {my[3], my[2], my[1], my[0]};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            mx[k] = 8'h00;
            my[k] = 8'h00;
        end
    endtask

    // Present n samples (arrival order) with optional random idle gaps.
    task automatic feed(input logic [31:0] xs, input logic [31:0] ys, input int n,
                        input int max_gap, input bit hold,
                        input logic [7:0] nx, input logic [7:0] ny);
        for (int k = 0; k < n; k++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int i = 0; i < g; i++) begin
                bus.in_valid = 1'b0;
                tick();
                chk1("gap_in_ready", bus.in_ready, 1'b1);
            end
            bus.in_valid = 1'b1;
            bus.in_x     = xs[31-8*k -: 8];
            bus.in_y     = ys[31-8*k -: 8];
            chk1("fill_in_ready", bus.in_ready, 1'b1);
            tick();
            mx[k] = xs[31-8*k -: 8];
            my[k] = ys[31-8*k -: 8];
            chk("lane_x", bus.mac_x, lanes_x());
            chk("lane_y", bus.mac_y, lanes_y());
            chk1("fill_no_res_valid", bus.res_valid, 1'b0);
            if (k == 3) begin
                chk1("start_in_ready", bus.in_ready, 1'b0);
                chk1("start_mac_start", bus.mac_start, 1'b1);
            end
        end
        if (hold) begin
            bus.in_x = nx;
            bus.in_y = ny;
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    // MAC model: ready stays high for pre cycles, busy for busy (>=1) cycles,
    // then returns res with mac_ready high.
    task automatic run_mac(input int pre, input int busy, input logic [19:0] res);
        for (int i = 0; i < pre; i++) begin
            tick();
            chk1("start_hold_mac_start", bus.mac_start, 1'b1);
            chk1("start_hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.mac_ready = 1'b0;
        bus.mac_out   = 20'($urandom);
        for (int i = 0; i < busy; i++) begin
            tick();
            chk1("wait_mac_start", bus.mac_start, 1'b0);
            chk1("wait_in_ready", bus.in_ready, 1'b0);
            chk1("wait_res_valid", bus.res_valid, 1'b0);
        end
        bus.mac_out   = res;
        bus.mac_ready = 1'b1;
        tick();
        chk1("res_valid", bus.res_valid, 1'b1);
        chk("res_real", 32'(bus.res_real), 32'(res / 1024));
        chk("res_imag", 32'(bus.res_imag), 32'(res % 1024));
        chk1("done_in_ready", bus.in_ready, 1'b1);
        chk1("err", bus.err, exp_err);
        exp_rv++;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mac_x"}, bus.mac_x, 32'h0);
        chk({tag, "_mac_y"}, bus.mac_y, 32'h0);
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        chk1({tag, "_mac_start"}, bus.mac_start, 1'b0);
        chk1({tag, "_res_valid"}, bus.res_valid, 1'b0);
        chk({tag, "_res_real"}, 32'(bus.res_real), 32'h0);
        chk({tag, "_res_imag"}, 32'(bus.res_imag), 32'h0);
        chk1({tag, "_err"}, bus.err, 1'b0);
    endtask

    initial begin
        tbl[0] = '{32'h70572553, 32'h70251435, 20'h2A0C5, 3, 1'b1,
                   32'h53255770, 32'h35142570, 10'h0A8, 10'h0C5};
        tbl[1] = '{32'h11223344, 32'hFF00A55A, 20'hFFFFF, 0, 1'b1,
                   32'h44332211, 32'h5AA500FF, 10'h3FF, 10'h3FF};
        tbl[2] = '{32'h01020304, 32'h80402010, 20'h00000, 1, 1'b0,
                   32'h04030201, 32'h10204080, 10'h000, 10'h000};
        tbl[3] = '{32'hDEADBEEF, 32'hCAFEF00D, 20'h80200, 2, 1'b0,
                   32'hEFBEADDE, 32'h0DF0FECA, 10'h200, 10'h200};

        bus.in_valid  = 1'b0;
        bus.in_x      = 8'h00;
        bus.in_y      = 8'h00;
        bus.mac_ready = 1'b1;
        bus.mac_out   = 20'h0;
        clear_model();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        tick();

        // Directed table, back-to-back batches.
        for (int t = 0; t < 4; t++) begin
            int nt;
            nt = (t < 3) ? t + 1 : t;
            feed(tbl[t].xs, tbl[t].ys, 4, 0, tbl[t].hold,
                 tbl[nt].xs[31:24], tbl[nt].ys[31:24]);
            chk("tbl_mac_x", bus.mac_x, tbl[t].ex);
            chk("tbl_mac_y", bus.mac_y, tbl[t].ey);
            run_mac(tbl[t].pre, 2, tbl[t].res);
            chk("tbl_res_real", 32'(bus.res_real), 32'(tbl[t].er));
            chk("tbl_res_imag", 32'(bus.res_imag), 32'(tbl[t].ei));
        end
        tick();
        chk1("res_valid_one_cycle", bus.res_valid, 1'b0);
        chk1("idle_in_ready", bus.in_ready, 1'b1);

        // Reset after two handshakes discards the partial batch.
        feed(32'h99887766, 32'h12345678, 2, 0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("rst_partial");
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        tick();
        feed(32'hA1B2C3D4, 32'h0F1E2D3C, 4, 0, 1'b0, 8'h00, 8'h00);
        chk("fresh_mac_x", bus.mac_x, 32'hD4C3B2A1);
        chk("fresh_mac_y", bus.mac_y, 32'h3C2D1E0F);
        run_mac(0, 1, 20'h3C00F);

        // Reset while the MAC is busy: no result for that operation.
        feed(32'h0A0B0C0D, 32'h10203040, 4, 0, 1'b0, 8'h00, 8'h00);
        bus.mac_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_reset_values("rst_inflight");
        clear_model();
        bus.mac_out   = 20'h12345;
        bus.mac_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        chk("inflight_no_res_valid", 32'(rv_count), 32'(exp_rv));
        chk1("inflight_in_ready", bus.in_ready, 1'b1);

        // Randomized batches against the reference model.
        for (int b = 0; b < 20; b++) begin
            logic [31:0] xs, ys, ex, ey;
            logic [19:0] res;
            xs  = $urandom;
            ys  = $urandom;
            res = 20'($urandom);
            ex  = 32'h0;
            ey  = 32'h0;
            for (int k = 0; k < 4; k++) begin
                ex = ex | (32'(xs[31-8*k -: 8]) << (8 * k));
                ey = ey | (32'(ys[31-8*k -: 8]) << (8 * k));
            end
            feed(xs, ys, 4, 2, 1'b0, 8'h00, 8'h00);
            chk("rand_mac_x", bus.mac_x, ex);
            chk("rand_mac_y", bus.mac_y, ey);
            run_mac(int'($urandom_range(3, 0)), int'($urandom_range(4, 1)), res);
        end

        // MAC stuck busy.
        feed(32'h55AA55AA, 32'hAA55AA55, 4, 0, 1'b0, 8'h00, 8'h00);
`ifdef MAC_FEEDER_TIMEOUT_EN
        begin
            int n;
            n = 0;
            bus.mac_ready = 1'b0;
            while (!bus.err && n < 400) begin
                tick();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'd255);
            chk1("tmo_err", bus.err, 1'b1);
            chk1("tmo_in_ready", bus.in_ready, 1'b1);
            chk1("tmo_mac_start", bus.mac_start, 1'b0);
            exp_err = 1'b1;
            bus.mac_ready = 1'b1;
            repeat (3) tick();
            chk("tmo_no_res_valid", 32'(rv_count), 32'(exp_rv));
            feed(32'h01234567, 32'h89ABCDEF, 4, 0, 1'b0, 8'h00, 8'h00);
            run_mac(1, 1, 20'hABCDE);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk1("err_cleared_by_rst", bus.err, 1'b0);
            exp_err = 1'b0;
            @(negedge clk);
            rst = 1'b0;
        end
`else
        run_mac(0, 300, 20'h5A5A5);
        chk1("no_tmo_err", bus.err, 1'b0);
`endif

        repeat (3) tick();
        chk("res_valid_total", 32'(rv_count), 32'(exp_rv));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
